// File: rtl/ysyx_axi4_sram_slave.sv
// AXI4 memory responder with independent read/write channels, INCR/FIXED bursts and a
// programmable first-beat read latency. It is backed by a non-reset 64-bit word array.
module ysyx_axi4_sram_slave #(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 64,
  parameter int                DEPTH   = 4096,
  parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
  parameter int                LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          arburst,
  input  logic [2:0]          arsize,
  input  logic [7:0]          arlen,
  input  logic [3:0]          arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready_o,
  output logic [3:0]          rid_o,
  output logic                rlast_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic                rvalid_o,
  input  logic                rready,
  input  logic [1:0]          awburst,
  input  logic [2:0]          awsize,
  input  logic [7:0]          awlen,
  input  logic [3:0]          awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready_o,
  output logic [3:0]          bid_o,
  output logic [1:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready
);

  localparam int              IDX_W  = $clog2(DEPTH);
  localparam int              STRB_W = DATA_W / 8;
  localparam int              LAT    = (LATENCY < 1) ? 1 : LATENCY;
  localparam logic [ADDR_W:0] LIMIT  = {1'b0, BASE} + (ADDR_W+1)'(8 * DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  function automatic logic addr_err(input logic [ADDR_W-1:0] a, input logic [2:0] size);
    return (a < BASE) || ({1'b0, a} >= LIMIT) || (size > 3'd3);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE) >> 3);
  endfunction

  // WRAP is deliberately handled like INCR.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0] burst,
                                                  input logic [2:0] size);
    return (burst == 2'b00) ? a : a + (ADDR_W'(1) << size);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- read channel ----------------
  r_state_t          r_state, r_next;
  logic [ADDR_W-1:0] r_addr, r_fetch;
  logic [7:0]        r_len, r_beat, r_cnt;
  logic [1:0]        r_burst;
  logic [2:0]        r_size;
  logic              ar_fire, r_fire, r_load, r_fetch_err;

  assign arready_o   = (r_state == R_IDLE);
  assign rvalid_o    = (r_state == R_DATA);
  assign rlast_o     = rvalid_o && (r_beat == r_len);
  assign ar_fire     = arvalid && arready_o;
  assign r_fire      = rvalid_o && rready;
  assign r_load      = ((r_state == R_WAIT) && (r_cnt == '0)) || (r_fire && !rlast_o);
  assign r_fetch     = (r_state == R_DATA) ? next_addr(r_addr, r_burst, r_size) : r_addr;
  assign r_fetch_err = addr_err(r_fetch, r_size);

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (arvalid)               r_next = R_WAIT;
      R_WAIT:  if (r_cnt == '0)           r_next = R_DATA;
      R_DATA:  if (r_fire && rlast_o)     r_next = R_IDLE;
      default:                            r_next = R_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; this is also what makes a same-cycle read see pre-write data.
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rid_o   <= '0;
      rdata_o <= '0;
      rresp_o <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_burst <= '0;
      r_size  <= '0;
      r_cnt   <= '0;
    end else begin
      if (ar_fire) begin
        rid_o   <= arid;
        r_addr  <= araddr;
        r_len   <= arlen;
        r_burst <= arburst;
        r_size  <= arsize;
        r_beat  <= '0;
        r_cnt   <= 8'(LAT - 1);
      end else if ((r_state == R_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 8'd1;
      end
      // A beat is fetched once and then held until its handshake.
      if (r_load) begin
        rdata_o <= r_fetch_err ? '0 : mem[word_idx(r_fetch)];
        rresp_o <= r_fetch_err ? 2'b10 : 2'b00;
        if (r_state == R_DATA) begin
          r_addr <= r_fetch;
          r_beat <= r_beat + 8'd1;
        end
      end
    end
  end

  // ---------------- write channel ----------------
  w_state_t          w_state, w_next;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len, w_beat;
  logic [1:0]        w_burst;
  logic [2:0]        w_size;
  logic              w_err, aw_fire, w_fire, b_fire, w_beat_err, w_count_end, w_end;

  assign awready_o   = (w_state == W_IDLE);
  assign wready_o    = (w_state == W_DATA);
  assign bvalid_o    = (w_state == W_RESP);
  assign aw_fire     = awvalid && awready_o;
  assign w_fire      = wvalid && wready_o;
  assign b_fire      = bvalid_o && bready;
  assign w_beat_err  = addr_err(w_addr, w_size);
  assign w_count_end = (w_beat == w_len);
  assign w_end       = w_fire && (wlast || w_count_end);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (awvalid) w_next = W_DATA;
      W_DATA:  if (w_end)   w_next = W_RESP;
      W_RESP:  if (b_fire)  w_next = W_IDLE;
      default:              w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bid_o   <= '0;
      bresp_o <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_burst <= '0;
      w_size  <= '0;
      w_err   <= 1'b0;
    end else begin
      if (aw_fire) begin
        bid_o   <= awid;
        w_addr  <= awaddr;
        w_len   <= awlen;
        w_burst <= awburst;
        w_size  <= awsize;
        w_beat  <= '0;
        w_err   <= 1'b0;
      end
      if (w_fire) begin
        w_addr <= next_addr(w_addr, w_burst, w_size);
        w_beat <= w_beat + 8'd1;
        w_err  <= w_err | w_beat_err;
        // A wlast that disagrees with the beat count is reported but still closes the burst.
        if (w_end)
          bresp_o <= (w_err || w_beat_err || (wlast != w_count_end)) ? 2'b10 : 2'b00;
      end
    end
  end

  // NOTE: the array is intentionally not reset; clearing every word on reset is not
  // required and would prevent mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst && w_fire && !w_beat_err) begin
      for (int i = 0; i < STRB_W; i++)
        if (wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule
